// File: rtl/tt_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : tt_capture_if
//  Purpose  : Word-stream handshake bundle between the truth-table capture
//             engine (master) and its consumer (slave).
//  Signals  : word_valid  master->slave  word available
//             word_ready  slave->master  consumer accepts when high with valid
//             word_data   master->slave  32-bit slice of the truth table
//             word_idx    master->slave  index of the offered word (3 down to 0)
//  Revision : 1.0  initial release
// ============================================================================
interface tt_capture_if;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic [1:0]  word_idx;

    modport master (
        output word_valid,
        output word_data,
        output word_idx,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        input  word_idx,
        output word_ready
    );
endinterface
`default_nettype wire

// File: rtl/tt_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tt_capture
//  Purpose  : Sweeps all 128 minterms of a 7-input function block, samples its
//             output for each, assembles the 128-bit truth table, counts the
//             onset and streams the table as four 32-bit words, MS word first.
//  Ports    : clk     rising-edge clock
//             rst_n   asynchronous active-low reset
//             start   begin a capture (sampled only while idle)
//             x       minterm presented to the function block
//             f_in    function block output for the current x
//             busy    capture or stream in progress
//             done    single-cycle pulse after the last word is accepted
//             tt      captured truth table, bit i = f(x = i)
//             ones    onset count (0..128)
//             stream  word stream (valid/ready/data/idx), master side
//  Params   : SETTLE  wait cycles between presenting x and sampling f_in (0..15)
//  Revision : 1.0  initial release
// ============================================================================
module tt_capture #(
    parameter int unsigned SETTLE = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         start,
    output logic [6:0]        x,
    input  wire logic         f_in,
    output logic              busy,
    output logic              done,
    output logic [127:0]      tt,
    output logic [7:0]        ones,
    tt_capture_if.master      stream
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SWEEP  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    localparam logic [3:0] C_SETTLE = 4'(SETTLE);
    localparam logic [6:0] C_LAST   = 7'd127;

    logic [1:0]   state_q, state_d;
    logic [6:0]   idx_q,   idx_d;
    logic [3:0]   cnt_q,   cnt_d;
    logic [127:0] tt_q,    tt_d;
    logic [7:0]   ones_q,  ones_d;
    logic [1:0]   widx_q,  widx_d;
    logic         busy_q,  busy_d;
    logic         done_q,  done_d;
    logic         wval_q,  wval_d;

    logic         w_hs;

    assign w_hs = wval_q & stream.word_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if ((cnt_q == 4'd0) && (idx_q == C_LAST)) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_hs && (widx_q == 2'd0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath / output next-values
    // ------------------------------------------------------------------
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        tt_d   = tt_q;
        ones_d = ones_q;
        widx_d = widx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tt_d   = '0;
                    ones_d = '0;
                    idx_d  = '0;
                    cnt_d  = C_SETTLE;
                end
            end
            S_SWEEP: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    tt_d[idx_q] = f_in;
                    ones_d      = ones_q + {7'd0, f_in};
                    if (idx_q == C_LAST) begin
                        // x stays parked on 127 until the next start
                        widx_d = 2'd3;
                    end else begin
                        idx_d = idx_q + 7'd1;
                        cnt_d = C_SETTLE;
                    end
                end
            end
            S_STREAM: begin
                if (w_hs) begin
                    // the last accepted word leaves word_idx at 0, not wrapped
                    widx_d = (widx_q != 2'd0) ? (widx_q - 2'd1) : 2'd0;
                end
            end
            default: ;
        endcase

        // flags are derived from the upcoming state so they are registered
        busy_d = (state_d != S_IDLE);
        wval_d = (state_d == S_STREAM);
        done_d = (state_q == S_STREAM) && w_hs && (widx_q == 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            tt_q   <= '0;
            ones_q <= '0;
            widx_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            wval_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            tt_q   <= tt_d;
            ones_q <= ones_d;
            widx_q <= widx_d;
            busy_q <= busy_d;
            done_q <= done_d;
            wval_q <= wval_d;
        end
    end

    assign x                 = idx_q;
    assign tt                = tt_q;
    assign ones              = ones_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign stream.word_valid = wval_q;
    assign stream.word_idx   = widx_q;
    assign stream.word_data  = tt_q[{widx_q, 5'd0} +: 32];

endmodule
`default_nettype wire

// File: tb/tb_tt_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tt_capture
//  Purpose  : Self-checking bench for tt_capture. Two instances (SETTLE=0 and
//             SETTLE=1) share a function table; the expected truth table,
//             onset count, words and timing come from the table itself.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tt_capture;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         ready = 1'b0;
    logic         sel   = 1'b0;
    logic [127:0] ftab  = '0;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    logic [6:0]   x0, x1;
    logic         busy0, busy1, done0, done1;
    logic [127:0] tt0, tt1;
    logic [7:0]   ones0, ones1;
    logic         f0, f1, start0, start1;

    tt_capture_if if0 ();
    tt_capture_if if1 ();

    assign f0 = ftab[x0];
    assign f1 = ftab[x1];
    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign if0.word_ready = ready;
    assign if1.word_ready = ready;

    tt_capture #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .x(x0), .f_in(f0),
        .busy(busy0), .done(done0), .tt(tt0), .ones(ones0), .stream(if0)
    );

    tt_capture #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .x(x1), .f_in(f1),
        .busy(busy1), .done(done1), .tt(tt1), .ones(ones1), .stream(if1)
    );

    logic [6:0]   m_x;
    logic         m_busy, m_done, m_wvalid;
    logic [127:0] m_tt;
    logic [7:0]   m_ones;
    logic [31:0]  m_wdata;
    logic [1:0]   m_widx;

    assign m_x      = sel ? x1 : x0;
    assign m_busy   = sel ? busy1 : busy0;
    assign m_done   = sel ? done1 : done0;
    assign m_tt     = sel ? tt1 : tt0;
    assign m_ones   = sel ? ones1 : ones0;
    assign m_wvalid = sel ? if1.word_valid : if0.word_valid;
    assign m_wdata  = sel ? if1.word_data : if0.word_data;
    assign m_widx   = sel ? if1.word_idx : if0.word_idx;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_x"},     128'(m_x), 0);
        chk({pfx, "_tt"},    m_tt, 0);
        chk({pfx, "_ones"},  128'(m_ones), 0);
        chk({pfx, "_widx"},  128'(m_widx), 0);
        chk({pfx, "_busy"},  128'(m_busy), 0);
        chk({pfx, "_done"},  128'(m_done), 0);
        chk({pfx, "_valid"}, 128'(m_wvalid), 0);
    endtask

    // Accept a start on the selected instance; returns at the negedge after E0.
    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("launch_x", 128'(m_x), 0);
        chk("launch_busy", 128'(m_busy), 1);
        chk("launch_tt", m_tt, 0);
        chk("launch_ones", 128'(m_ones), 0);
    endtask

    // Runs the rest of a capture from the negedge after E0 to the done pulse.
    // bp: 0 ready always high, 1 random ready, 2 five-cycle stall on word 2.
    task automatic drain(input logic [127:0] f, input int bp, input bit spam,
                         input bit hold_next, input logic [127:0] fnext);
        int s;
        int edges;
        int k;
        int lowcnt;
        int guard;
        logic [127:0] fv;
        s = sel ? 1 : 0;
        fv = f;
        edges = 0;
        guard = 0;
        while (!m_wvalid && guard < 4000) begin
            if (spam) start = 1'($urandom_range(0, 1));
            @(posedge clk);
            edges++;
            guard++;
            @(negedge clk);
        end
        chk("stream_valid_seen", 128'(m_wvalid), 1);
        chk("stream_entry_edge", 128'(edges), 128'(128 * (s + 1)));
        chk("final_tt", m_tt, fv);
        chk("final_ones", 128'(m_ones), 128'($countones(fv)));
        chk("stream_busy", 128'(m_busy), 1);

        k = 3;
        lowcnt = 0;
        guard = 0;
        while (k >= 0 && guard < 200) begin
            chk("word_data", 128'(m_wdata), 128'(fv[32 * k +: 32]));
            chk("word_idx", 128'(m_widx), 128'(k));
            chk("word_valid", 128'(m_wvalid), 1);
            chk("word_nodone", 128'(m_done), 0);
            case (bp)
                1: ready = 1'($urandom_range(0, 1));
                2: begin
                    if (k == 2 && lowcnt < 5) begin
                        ready = 1'b0;
                        lowcnt++;
                    end else begin
                        ready = 1'b1;
                    end
                end
                default: ready = 1'b1;
            endcase
            if (spam) start = 1'($urandom_range(0, 1));
            @(posedge clk);
            edges++;
            guard++;
            if (ready) k--;
            @(negedge clk);
        end
        chk("stream_complete", 128'(k < 0), 1);
        ready = 1'b0;
        start = 1'b0;
        chk("done_pulse", 128'(m_done), 1);
        chk("done_busy", 128'(m_busy), 0);
        chk("done_valid", 128'(m_wvalid), 0);
        chk("done_widx", 128'(m_widx), 0);
        chk("done_x", 128'(m_x), 127);
        if (bp == 0) chk("done_edge", 128'(edges), 128'(128 * (s + 1) + 4));

        if (hold_next) begin
            ftab = fnext;
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            chk("chain_done_drop", 128'(m_done), 0);
            chk("chain_busy", 128'(m_busy), 1);
            chk("chain_tt_clear", m_tt, 0);
            chk("chain_ones_clear", 128'(m_ones), 0);
            chk("chain_x", 128'(m_x), 0);
        end else begin
            @(posedge clk);
            @(negedge clk);
            chk("after_done_drop", 128'(m_done), 0);
            chk("after_busy", 128'(m_busy), 0);
        end
    endtask

    function automatic logic [127:0] make_tab(input int kind);
        logic [127:0] t;
        int b0, b1, b2;
        t = '0;
        for (int i = 0; i < 128; i++) begin
            b0 = i % 2;
            b1 = (i / 2) % 2;
            b2 = (i / 4) % 2;
            case (kind)
                1: t[i] = (b0 == 1);
                2: t[i] = ((b0 + b1 + b2) >= 2);
                3: t[i] = (i == 127);
                4: t[i] = (i >= 64);
                default: t[i] = 1'b0;
            endcase
        end
        return t;
    endfunction

    initial begin
        logic [127:0] fr;
        logic [127:0] fr2;
        int guard;

        // reset state of both instances
        repeat (3) @(negedge clk);
        sel = 1'b0;
        chk_zero("rst0");
        sel = 1'b1;
        chk_zero("rst1");
        rst_n = 1'b1;

        // constant 0, SETTLE=0
        sel = 1'b0;
        ftab = make_tab(0);
        launch();
        drain(ftab, 0, 1'b0, 1'b0, '0);

        // f = x0, SETTLE=1
        sel = 1'b1;
        ftab = make_tab(1);
        chk("tab_x0_word", 128'(ftab[31:0]), 128'(32'hAAAAAAAA));
        launch();
        drain(ftab, 0, 1'b0, 1'b0, '0);

        // majority of x0..x2, SETTLE=0
        sel = 1'b0;
        ftab = make_tab(2);
        chk("tab_maj_word", 128'(ftab[127:96]), 128'(32'hE8E8E8E8));
        launch();
        drain(ftab, 0, 1'b0, 1'b0, '0);

        // AND of all inputs
        ftab = make_tab(3);
        launch();
        drain(ftab, 0, 1'b0, 1'b0, '0);

        // f = x6 with a five-cycle stall on word 2
        ftab = make_tab(4);
        launch();
        drain(ftab, 2, 1'b0, 1'b0, '0);

        // reset at minterm 60 mid-sweep, then a full random capture
        ftab = {$urandom, $urandom, $urandom, $urandom};
        launch();
        guard = 0;
        while (m_x != 7'd60 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_minterm60", 128'(m_x), 60);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        launch();
        drain(ftab, 0, 1'b0, 1'b0, '0);

        // start spam during sweep/stream, then start held into the done cycle
        sel = 1'b1;
        fr  = {$urandom, $urandom, $urandom, $urandom};
        fr2 = {$urandom, $urandom, $urandom, $urandom};
        ftab = fr;
        launch();
        drain(fr, 1, 1'b1, 1'b1, fr2);
        drain(fr2, 0, 1'b0, 1'b0, '0);

        // a few more random captures with random backpressure
        for (int n = 0; n < 4; n++) begin
            sel = 1'(n % 2);
            ftab = {$urandom, $urandom, $urandom, $urandom};
            launch();
            drain(ftab, 1, 1'b0, 1'b0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
